// File: rtl/cf_overlay_pkg.sv
// rtl/cf_overlay_pkg.sv - shared types and constants for the correlation-filter overlay blocks
package cf_overlay_pkg;

    typedef enum logic [1:0] {
        NO_TARGET = 2'd0,
        TRACKING  = 2'd1,
        COASTING  = 2'd2
    } roi_state_t;

    localparam int DEF_NPPC           = 4;
    localparam int DEF_POSITION_WIDTH = 12;
    localparam int DEF_FFT_LENGTH     = 64;
    localparam int DEF_FRAME_WIDTH    = 3840;
    localparam int DEF_HEIGHT         = 2160;
    localparam int DEF_MISS_LIMIT     = 8;

    localparam int MAX_X = DEF_FRAME_WIDTH - DEF_FFT_LENGTH;
    localparam int MAX_Y = DEF_HEIGHT - DEF_FFT_LENGTH;

    // Largest legal ROI corner so the FFT window stays inside the frame.
    function automatic int max_coord(input int extent, input int fft_length);
        return extent - fft_length;
    endfunction

    // Clears the low bits so x lands on a beat boundary.
    function automatic int align_mask(input int nppc);
        return ~(nppc - 1);
    endfunction

endpackage

// File: rtl/cf_frame_tracker.sv
// rtl/cf_frame_tracker.sv - line counter and sof/eol/eof decode from a snooped video handshake
module cf_frame_tracker #(
    parameter int POSITION_WIDTH = 12,
    parameter int HEIGHT         = 2160
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tvalid,
    input  logic                      tready,
    input  logic                      tuser,
    input  logic                      tlast,
    output logic                      sof,
    output logic                      eol,
    output logic                      eof,
    output logic [POSITION_WIDTH-1:0] line
);

    localparam logic [POSITION_WIDTH-1:0] LAST_LINE = POSITION_WIDTH'(HEIGHT - 1);
    localparam logic [POSITION_WIDTH-1:0] ONE       = POSITION_WIDTH'(1);

    logic beat;

    assign beat = tvalid & tready;
    assign sof  = beat & tuser;
    assign eol  = beat & tlast;
    assign eof  = eol & (line == LAST_LINE);

    // A one-beat first line (sof and eol together) has already finished line 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (sof) begin
            line <= eol ? ONE : '0;
        end else if (eol) begin
            line <= eof ? '0 : line + ONE;
        end
    end

endmodule

// File: rtl/cf_roi_scheduler.sv
// rtl/cf_roi_scheduler.sv - frame-synchronous ROI commit and track/coast/lost overlay control
module cf_roi_scheduler
    import cf_overlay_pkg::*;
#(
    parameter int NPPC           = DEF_NPPC,
    parameter int POSITION_WIDTH = DEF_POSITION_WIDTH,
    parameter int FFT_LENGTH     = DEF_FFT_LENGTH,
    parameter int FRAME_WIDTH    = DEF_FRAME_WIDTH,
    parameter int HEIGHT         = DEF_HEIGHT,
    parameter int MISS_LIMIT     = DEF_MISS_LIMIT
) (
    input  logic                        s_axis_video_aclk,
    input  logic                        s_axis_video_areset,
    input  logic [2*POSITION_WIDTH-1:0] pos_tdata,
    input  logic                        pos_tvalid,
    output logic                        pos_tready,
    input  logic                        mon_tvalid,
    input  logic                        mon_tready,
    input  logic                        mon_tuser,
    input  logic                        mon_tlast,
    output logic [POSITION_WIDTH-1:0]   xStart,
    output logic [POSITION_WIDTH-1:0]   yStart,
    output logic                        overlay_en,
    output logic [15:0]                 frame_cnt,
    output logic                        pos_overwrite
);

    localparam int PW = POSITION_WIDTH;
    localparam logic [PW-1:0] LIM_X    = PW'(max_coord(FRAME_WIDTH, FFT_LENGTH));
    localparam logic [PW-1:0] LIM_Y    = PW'(max_coord(HEIGHT, FFT_LENGTH));
    localparam logic [PW-1:0] X_MASK   = PW'(align_mask(NPPC));
    localparam logic [7:0]    MISS_LIM = 8'(MISS_LIMIT);

    logic          clk;
    logic          rst;
    logic          trk_sof;
    logic          trk_eol;
    logic          eof;
    logic [PW-1:0] trk_line;
    logic          unused_trk;

    assign clk = s_axis_video_aclk;
    assign rst = s_axis_video_areset;

    cf_frame_tracker #(
        .POSITION_WIDTH(PW),
        .HEIGHT        (HEIGHT)
    ) u_frame_tracker (
        .clk   (clk),
        .rst   (rst),
        .tvalid(mon_tvalid),
        .tready(mon_tready),
        .tuser (mon_tuser),
        .tlast (mon_tlast),
        .sof   (trk_sof),
        .eol   (trk_eol),
        .eof   (eof),
        .line  (trk_line)
    );

    assign unused_trk = ^{trk_sof, trk_eol, trk_line};

    logic          accept;
    logic          commit;
    logic [PW-1:0] in_x;
    logic [PW-1:0] in_y;
    logic [PW-1:0] clamp_x;
    logic [PW-1:0] clamp_y;
    logic          pend_vld;
    logic [PW-1:0] pend_x;
    logic [PW-1:0] pend_y;

    assign accept  = pos_tvalid & pos_tready;
    assign commit  = eof;
    assign in_x    = pos_tdata[PW-1:0];
    assign in_y    = pos_tdata[2*PW-1:PW];
    assign clamp_x = ((in_x > LIM_X) ? LIM_X : in_x) & X_MASK;
    assign clamp_y = (in_y > LIM_Y) ? LIM_Y : in_y;

    // Accept wins over commit: the commit consumed the old contents this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_x   <= '0;
            pend_y   <= '0;
        end else if (accept) begin
            pend_vld <= 1'b1;
            pend_x   <= clamp_x;
            pend_y   <= clamp_y;
        end else if (commit) begin
            pend_vld <= 1'b0;
        end
    end

    roi_state_t state;
    roi_state_t state_d;
    logic [7:0] miss;
    logic [7:0] miss_d;
    logic       load;

    always_comb begin
        state_d = state;
        miss_d  = miss;
        load    = 1'b0;
        if (commit) begin
            if (pend_vld) begin
                load    = 1'b1;
                miss_d  = 8'd0;
                state_d = TRACKING;
            end else begin
                case (state)
                    TRACKING: begin
                        miss_d  = 8'd1;
                        state_d = (MISS_LIM == 8'd1) ? NO_TARGET : COASTING;
                    end
                    COASTING: begin
                        miss_d = miss + 8'd1;
                        if (miss_d == MISS_LIM) begin
                            state_d = NO_TARGET;
                        end
                    end
                    default: state_d = NO_TARGET;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= NO_TARGET;
            miss          <= 8'd0;
            xStart        <= '0;
            yStart        <= '0;
            overlay_en    <= 1'b0;
            frame_cnt     <= 16'd0;
            pos_overwrite <= 1'b0;
            pos_tready    <= 1'b0;
        end else begin
            state         <= state_d;
            miss          <= miss_d;
            overlay_en    <= (state_d != NO_TARGET);
            pos_overwrite <= accept & pend_vld & ~commit;
            pos_tready    <= 1'b1;
            if (load) begin
                xStart <= pend_x;
                yStart <= pend_y;
            end
            if (commit) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/cf_roi_scheduler.md
# cf_roi_scheduler

Frame-synchronous controller that owns the `xStart`/`yStart` region-of-interest (ROI) inputs of the correlation-filter overlay. It accepts ROI updates from the tracker over a valid/ready channel and holds one pending update. It snoops the handshake of the video stream entering the overlay and commits the pending update only at end of frame, so the overlay never changes position mid-frame. It also runs a track/coast/lost state machine that drives an overlay enable.

## Interface
- `NPPC`, 4: pixels per beat; power of two.
- `POSITION_WIDTH`, 12: width of ROI coordinates and the line counter.
- `FFT_LENGTH`, 64: ROI side in pixels.
- `FRAME_WIDTH`, 3840: active pixels per line.
- `HEIGHT`, 2160: lines per frame.
- `MISS_LIMIT`, 8: consecutive frames without an update before the target is declared lost; range 1..255.

- `s_axis_video_aclk`  in  1  sole clock.
- `s_axis_video_areset`  in  1  asynchronous, active-high reset.
- `pos_tdata`  in  2*POSITION_WIDTH  ROI top-left corner, `{y, x}`; y is the upper half.
- `pos_tvalid`  in  1  ROI update valid.
- `pos_tready`  out  1  ROI update accepted.
- `mon_tvalid`, `mon_tready`, `mon_tuser`, `mon_tlast`  in  1 each  snooped video handshake; never driven.
- `xStart`, `yStart`  out  POSITION_WIDTH  committed ROI corner, to the overlay.
- `overlay_en`  out  1  overlay drawing enable.
- `frame_cnt`  out  16  completed-frame count; wraps 0xFFFF→0.
- `pos_overwrite`  out  1  one-cycle pulse: a pending update was replaced before commit.

## Operation
- Beat: `mon_tvalid & mon_tready`.
  - sof = beat with `tuser`.
  - eol = beat with `tlast`.
  - eof = eol while line counter == HEIGHT-1.
- Line counter:
  - sof forces it to 0.
  - Otherwise each eol increments it.
  - eof wraps it to 0.
  - If sof and eol fall on the same beat, the counter goes to 1.
- Pending register: `pend_vld` plus a clamped `{y, x}`.
  - `pos_tready` is 1 whenever not in reset.
  - Every accepted beat overwrites the pending register (latest wins).
- Clamp on accept:
  - `x' = min(x, FRAME_WIDTH-FFT_LENGTH) & ~(NPPC-1)`.
  - `y' = min(y, HEIGHT-FFT_LENGTH)`.
- Commit event = eof. It uses the pending contents as they stand before that cycle's accept. An update accepted on the eof cycle stays pending for the next frame.
- State machine (2-bit `state`):
  - NO_TARGET: on commit with `pend_vld`, load the ROI, set miss=0, go to TRACKING. Otherwise stay.
  - TRACKING: on commit with `pend_vld`, load the ROI and set miss=0. Without `pend_vld`, set miss=1 and go to COASTING; if MISS_LIMIT==1, go to NO_TARGET instead.
  - COASTING: on commit with `pend_vld`, load the ROI, set miss=0, go to TRACKING. Without `pend_vld`, increment miss; at miss==MISS_LIMIT go to NO_TARGET.
  - In every state, a commit clears `pend_vld`.
  - `overlay_en = (state != NO_TARGET)`, registered.
  - `xStart`/`yStart` hold their last value in NO_TARGET.
- `frame_cnt` increments on every eof, in every state.
- `pos_overwrite` pulses when an accept occurs while `pend_vld` is 1 and no commit happens in the same cycle.

## Timing
- Reset values:
  - `xStart=0`, `yStart=0`, `overlay_en=0`, `frame_cnt=0`, `pos_overwrite=0`, `pos_tready=0`.
  - Line counter = 0, `pend_vld=0`, miss=0, state = NO_TARGET.
- `pos_tready` rises on the first clock edge after reset deasserts.
- Commit latency: `xStart`/`yStart`/`overlay_en` update on the edge ending the eof cycle. They are stable from the following cycle, before any possible sof.
- Accept-to-pending: 1 cycle.
- Accept-to-output: until the next eof; worst case 1 frame.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-frame: all state clears. Commits cannot occur until the line counter next reaches HEIGHT-1 at an eol; the first sof resynchronises it.
- Beats with `mon_tready=0` or `mon_tvalid=0` are ignored.

## Structure
- `cf_overlay_pkg` holds:
  - state encodings NO_TARGET=0, TRACKING=1, COASTING=2;
  - derived constants `MAX_X = FRAME_WIDTH-FFT_LENGTH` and `MAX_Y = HEIGHT-FFT_LENGTH`;
  - the x-alignment mask.
- Sub-module `cf_frame_tracker`: line counter plus sof/eol/eof decode from the snooped handshake. It is reusable by other overlay blocks.
- The top level holds the pending register, clamp, state machine and counters.

## Test plan
- Reset, then 3 frames with no updates → `overlay_en=0`, `xStart=yStart=0`, `frame_cnt=3`.
- Update `{y=100, x=203}` mid-frame 0 → at the first eof, `xStart=200`, `yStart=100`, `overlay_en=1`. Values remain unchanged throughout that frame.
- Update `{y=4000, x=4000}` → commits `xStart=3776`, `yStart=2096`.
- Two updates in one frame, `{10,10}` then `{20,20}` → one `pos_overwrite` pulse; commit gives `xStart=20`, `yStart=20`.
- After TRACKING with MISS_LIMIT=8:
  - 7 frames without updates → `overlay_en=1`.
  - 8th eof → `overlay_en=0`, with `xStart`/`yStart` held.
  - A new update then returns to TRACKING at the next eof.
- Update accepted on the eof cycle → not committed at that eof; committed at the next eof.
- Async reset asserted mid-line 1000 → outputs go to reset values immediately. After sof, the next eof commits normally.
